// File: rtl/datamem_pkg.sv
// Shared types and default sizes for the dual-read-port data memory.
package datamem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    // Sweep engine state: clearing the array, or open for normal writes.
    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/datamem_clear_fsm.sv
// Sequential clear engine: walks clear_ptr over every word after reset or clr,
// and tells the array when a user write may be accepted.
module datamem_clear_fsm
    import datamem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              wr_ok,
    output logic              busy
);

    clr_state_e        state;
    clr_state_e        state_nxt;
    logic [ADDR_W-1:0] clear_ptr;

    // State register; reset always (re)starts a sweep.
    always_ff @(posedge clock) begin
        if (reset) state <= SWEEP;
        else       state <= state_nxt;
    end

    // Next state: leave SWEEP on the edge that clears the last word; clr only counts in READY.
    always_comb begin
        state_nxt = state;
        case (state)
            SWEEP:   if (clear_ptr == '1) state_nxt = READY;
            READY:   if (clr)             state_nxt = SWEEP;
            default: state_nxt = SWEEP;
        endcase
    end

    // Sweep pointer advances once per sweep edge and wraps to 0 after the last word.
    always_ff @(posedge clock) begin
        if (reset)                         clear_ptr <= '0;
        else if (state == SWEEP)           clear_ptr <= clear_ptr + 1'b1;
        else if (clr)                      clear_ptr <= '0;
    end

    // Outputs: no array write of any kind happens on a reset edge or on the clr edge.
    always_comb begin
        busy       = (state == SWEEP);
        sweep_we   = (state == SWEEP) && !reset;
        sweep_addr = clear_ptr;
        wr_ok      = (state == READY) && !clr && !reset;
    end

endmodule

// File: rtl/datamem_dp.sv
// Data memory with one write port and two registered read ports (A: load path,
// B: debug/display), optional write-to-read forwarding and a sweeping clear.
module datamem_dp
    import datamem_pkg::*;
#(
    parameter int               DATA_W    = DATA_W_DEF,
    parameter int               ADDR_W    = ADDR_W_DEF,
    parameter bit               BYPASS    = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c17,
    input  logic [ADDR_W-1:0] write_select,
    input  logic [DATA_W-1:0] inp,
    input  logic              clr,
    input  logic [ADDR_W-1:0] read_select_a,
    input  logic [ADDR_W-1:0] read_select_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              busy,
    output logic              wr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              wr_ok;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_a_nxt;
    logic [DATA_W-1:0] rd_b_nxt;

    datamem_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clock      (clock),
        .reset      (reset),
        .clr        (clr),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .wr_ok      (wr_ok),
        .busy       (busy)
    );

    // Write mux: the sweep owns the port while busy; user writes only when accepted.
    always_comb begin
        user_we   = c17 && wr_ok;
        mem_we    = sweep_we || user_we;
        mem_waddr = sweep_we ? sweep_addr : write_select;
        mem_wdata = sweep_we ? CLEAR_VAL  : inp;
    end

    // Storage array; deliberately not reset, the sweep engine clears it.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read selection: forced clear value while busy, forwarding only for a write that really lands.
    always_comb begin
        rd_a_nxt = mem[read_select_a];
        rd_b_nxt = mem[read_select_b];
        if (busy) begin
            rd_a_nxt = CLEAR_VAL;
            rd_b_nxt = CLEAR_VAL;
        end else if (BYPASS && user_we) begin
            if (read_select_a == write_select) rd_a_nxt = inp;
            if (read_select_b == write_select) rd_b_nxt = inp;
        end
    end

    // Registered read ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            data_out_a <= rd_a_nxt;
            data_out_b <= rd_b_nxt;
        end
    end

    // Dropped-write pulse: a write request on any edge that did not accept it.
    always_ff @(posedge clock) begin
        if (reset) wr_err <= 1'b0;
        else       wr_err <= c17 && !wr_ok;
    end

endmodule

// File: tb/tb_datamem_dp.sv
// Bench for datamem_dp: a forwarding and a non-forwarding instance driven in
// lockstep, checked against a per-cycle scoreboard built from a behavioural model.
module tb_datamem_dp;

    logic       clock = 1'b0;
    logic       reset, c17, clr;
    logic [3:0] ws, ra, rb;
    logic [7:0] inp;
    logic [7:0] a1, b1, a0, b0;
    logic       bsy1, bsy0, err1, err0;

    always #5 clock = ~clock;

    datamem_dp #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b1), .CLEAR_VAL(8'h00)) dut_byp (
        .clock(clock), .reset(reset), .c17(c17), .write_select(ws), .inp(inp), .clr(clr),
        .read_select_a(ra), .read_select_b(rb), .data_out_a(a1), .data_out_b(b1),
        .busy(bsy1), .wr_err(err1)
    );

    datamem_dp #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b0), .CLEAR_VAL(8'h00)) dut_old (
        .clock(clock), .reset(reset), .c17(c17), .write_select(ws), .inp(inp), .clr(clr),
        .read_select_a(ra), .read_select_b(rb), .data_out_a(a0), .data_out_b(b0),
        .busy(bsy0), .wr_err(err0)
    );

    typedef struct {
        logic [7:0] a1, b1, a0, b0;
        logic       bsy, err;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] m [16];
    logic       mbusy = 1'b1;
    logic [3:0] mptr  = 4'd0;

    // Drive one cycle, push the expected post-edge outputs, advance the model.
    task automatic drive(input logic rst, input logic we, input logic [3:0] wa,
                         input logic [7:0] d, input logic cl,
                         input logic [3:0] xa, input logic [3:0] xb);
        exp_t e;
        reset = rst; c17 = we; ws = wa; inp = d; clr = cl; ra = xa; rb = xb;
        if (rst) begin
            e.a1 = 8'h00; e.b1 = 8'h00; e.a0 = 8'h00; e.b0 = 8'h00; e.err = 1'b0;
            mbusy = 1'b1; mptr = 4'd0;
        end else if (mbusy) begin
            e.a1 = 8'h00; e.b1 = 8'h00; e.a0 = 8'h00; e.b0 = 8'h00; e.err = we;
            m[mptr] = 8'h00;
            if (mptr == 4'd15) mbusy = 1'b0;
            mptr = mptr + 4'd1;
        end else if (cl) begin
            e.a1 = m[xa]; e.a0 = m[xa]; e.b1 = m[xb]; e.b0 = m[xb]; e.err = we;
            mbusy = 1'b1; mptr = 4'd0;
        end else begin
            e.a1 = (we && xa == wa) ? d : m[xa];
            e.b1 = (we && xb == wa) ? d : m[xb];
            e.a0 = m[xa]; e.b0 = m[xb]; e.err = 1'b0;
            if (we) m[wa] = d;
        end
        e.bsy = mbusy;
        sb.push_back(e);
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 33; i++) begin
            if (i == 0)       drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0);
            else if (i <= 16) drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
            else              drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(i - 17), 4'(32 - i));
            e = sb.pop_front(); checks++;
            if ({a1, b1, a0, b0, bsy1, bsy0, err1, err0} !== {e.a1, e.b1, e.a0, e.b0, e.bsy, e.bsy, e.err, e.err}) begin
                failures++;
                $display("FAIL reset[%0d]: got a=%h/%h b=%h/%h busy=%b/%b err=%b/%b, want a=%h/%h b=%h/%h busy=%b err=%b",
                         i, a1, a0, b1, b0, bsy1, bsy0, err1, err0, e.a1, e.a0, e.b1, e.b0, e.bsy, e.err);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 4'd1);
                1:       drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 4'd3);
                default: drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 4'd5);
            endcase
            e = sb.pop_front(); checks++;
            if ({a1, b1, a0, b0, bsy1, bsy0, err1, err0} !== {e.a1, e.b1, e.a0, e.b0, e.bsy, e.bsy, e.err, e.err}) begin
                failures++;
                $display("FAIL write_read[%0d]: got a=%h/%h b=%h/%h busy=%b/%b err=%b/%b, want a=%h/%h b=%h/%h busy=%b err=%b",
                         i, a1, a0, b1, b0, bsy1, bsy0, err1, err0, e.a1, e.a0, e.b1, e.b0, e.bsy, e.err);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 4'd7, 8'h5A, 1'b0, 4'd7, 4'd3);
            else        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd7, 4'd7);
            e = sb.pop_front(); checks++;
            if ({a1, b1, a0, b0, bsy1, bsy0, err1, err0} !== {e.a1, e.b1, e.a0, e.b0, e.bsy, e.bsy, e.err, e.err}) begin
                failures++;
                $display("FAIL bypass[%0d]: got a=%h/%h b=%h/%h busy=%b/%b err=%b/%b, want a=%h/%h b=%h/%h busy=%b err=%b",
                         i, a1, a0, b1, b0, bsy1, bsy0, err1, err0, e.a1, e.a0, e.b1, e.b0, e.bsy, e.err);
            end
        end
    endtask

    task automatic test_clr();
        exp_t e;
        for (int i = 0; i < 50; i++) begin
            if (i < 16)       drive(1'b0, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 4'(i), 4'(i - 1));
            else if (i == 16) drive(1'b0, 1'b1, 4'd2, 8'hEE, 1'b1, 4'd2, 4'd9);
            else if (i <= 32) drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(i), 4'(i + 3));
            else if (i == 33) drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd2, 4'd15);
            else              drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(i - 34), 4'(49 - i));
            e = sb.pop_front(); checks++;
            if ({a1, b1, a0, b0, bsy1, bsy0, err1, err0} !== {e.a1, e.b1, e.a0, e.b0, e.bsy, e.bsy, e.err, e.err}) begin
                failures++;
                $display("FAIL clr[%0d]: got a=%h/%h b=%h/%h busy=%b/%b err=%b/%b, want a=%h/%h b=%h/%h busy=%b err=%b",
                         i, a1, a0, b1, b0, bsy1, bsy0, err1, err0, e.a1, e.a0, e.b1, e.b0, e.bsy, e.err);
            end
        end
    endtask

    task automatic test_midsweep();
        exp_t e;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4'(i), 8'(8'hC0 + i), 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) void'(sb.pop_front());
        for (int i = 0; i < 39; i++) begin
            if (i == 0)       drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 4'd2);
            else if (i <= 5)  drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd1, 4'd2);
            else if (i == 6)  drive(1'b1, 1'b1, 4'd1, 8'hFF, 1'b1, 4'd1, 4'd2);
            else if (i <= 22) drive(1'b0, 1'b1, 4'($urandom_range(15)), 8'($urandom_range(1, 255)),
                                    1'(i == 10), 4'($urandom_range(15)), 4'($urandom_range(15)));
            else              drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(i - 23), 4'(i - 22));
            e = sb.pop_front(); checks++;
            if ({a1, b1, a0, b0, bsy1, bsy0, err1, err0} !== {e.a1, e.b1, e.a0, e.b0, e.bsy, e.bsy, e.err, e.err}) begin
                failures++;
                $display("FAIL midsweep[%0d]: got a=%h/%h b=%h/%h busy=%b/%b err=%b/%b, want a=%h/%h b=%h/%h busy=%b err=%b",
                         i, a1, a0, b1, b0, bsy1, bsy0, err1, err0, e.a1, e.a0, e.b1, e.b0, e.bsy, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'($urandom_range(1)), 4'($urandom_range(3)), 8'($urandom_range(255)),
                  1'b0, 4'($urandom_range(3)), 4'($urandom_range(3)));
            e = sb.pop_front(); checks++;
            if ({a1, b1, a0, b0, bsy1, bsy0, err1, err0} !== {e.a1, e.b1, e.a0, e.b0, e.bsy, e.bsy, e.err, e.err}) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got a=%h/%h b=%h/%h busy=%b/%b err=%b/%b, want a=%h/%h b=%h/%h busy=%b err=%b",
                         i, a1, a0, b1, b0, bsy1, bsy0, err1, err0, e.a1, e.a0, e.b1, e.b0, e.bsy, e.err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; c17 = 1'b0; clr = 1'b0; ws = '0; ra = '0; rb = '0; inp = '0;
        for (int i = 0; i < 16; i++) m[i] = 8'hxx;
        #2;
        test_reset();
        test_write_read();
        test_bypass();
        test_clr();
        test_midsweep();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
